// File: rtl/forwarding_hazard_unit.sv
// Operand forwarding selects plus load-use stall / taken-branch flush control
// for a classic 5-stage pipeline, with saturating stall and flush statistics.
module forwarding_hazard_unit #(
    parameter int ADDR_W  = 5,
    parameter int NUM_SRC = 2,
    parameter int MEM_LAT = 0,
    parameter int CNT_W   = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_SRC*ADDR_W-1:0]   ars_id,
    input  logic [NUM_SRC*ADDR_W-1:0]   ars_ex,
    input  logic [ADDR_W-1:0]           ard_id_ex,
    input  logic                        regwrite_id_ex,
    input  logic                        memread_id_ex,
    input  logic [ADDR_W-1:0]           ard_ex_mem,
    input  logic [ADDR_W-1:0]           ard_mem_wb,
    input  logic                        regwrite_ex_mem,
    input  logic                        regwrite_mem_wb,
    input  logic                        branch_taken,
    output logic [2*NUM_SRC-1:0]        forward,
    output logic                        stall_if,
    output logic                        stall_id,
    output logic                        bubble_ex,
    output logic                        flush_id,
    output logic                        flush_ex,
    output logic [CNT_W-1:0]            stall_cnt,
    output logic [CNT_W-1:0]            flush_cnt
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        STALL = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};
    localparam logic [2:0]        LAT_INIT  = 3'(MEM_LAT);
    localparam bit                HAS_LAT   = (MEM_LAT > 0);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t      state_r;
    state_t      state_nxt_s;
    logic [2:0]  wait_cnt_r;
    logic [2:0]  wait_nxt_s;
    logic        lu_s;
    logic        stall_s;
    logic        flush_s;
    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] flush_cnt_r;

    // Counter holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val, input logic en);
        logic [CNT_W-1:0] res;
        if (en && (val != CNT_MAX)) begin
            res = val + CNT_ONE;
        end else begin
            res = val;
        end
        return res;
    endfunction

    // Per-slot forwarding select; the younger EX/MEM result wins over MEM/WB.
    always_comb begin
        forward = {(2*NUM_SRC){1'b0}};
        for (int i = 0; i < NUM_SRC; i++) begin
            if (regwrite_ex_mem && (ard_ex_mem != ZERO_ADDR) &&
                (ard_ex_mem == ars_ex[i*ADDR_W +: ADDR_W])) begin
                forward[2*i +: 2] = 2'b10;
            end else if (regwrite_mem_wb && (ard_mem_wb != ZERO_ADDR) &&
                         (ard_mem_wb == ars_ex[i*ADDR_W +: ADDR_W])) begin
                forward[2*i +: 2] = 2'b01;
            end else begin
                forward[2*i +: 2] = 2'b00;
            end
        end
    end

    // Load-use detection: a load in EX whose destination feeds any decode source.
    always_comb begin
        lu_s = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            lu_s = lu_s | (ars_id[i*ADDR_W +: ADDR_W] == ard_id_ex);
        end
        lu_s = lu_s & memread_id_ex & regwrite_id_ex & (ard_id_ex != ZERO_ADDR);
    end

    // Hazard FSM next-state; a taken branch overrides any stall in progress.
    always_comb begin
        stall_s     = 1'b0;
        flush_s     = 1'b0;
        state_nxt_s = state_r;
        wait_nxt_s  = wait_cnt_r;
        if (branch_taken) begin
            flush_s     = 1'b1;
            state_nxt_s = IDLE;
            wait_nxt_s  = 3'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (lu_s && HAS_LAT) begin
                        stall_s     = 1'b1;
                        state_nxt_s = STALL;
                        wait_nxt_s  = LAT_INIT;
                    end else begin
                        stall_s     = lu_s;
                        state_nxt_s = IDLE;
                        wait_nxt_s  = 3'd0;
                    end
                end
                STALL: begin
                    stall_s    = 1'b1;
                    wait_nxt_s = wait_cnt_r - 3'd1;
                    if (wait_cnt_r == 3'd1) begin
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = STALL;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                    wait_nxt_s  = 3'd0;
                end
            endcase
        end
    end

    // Control outputs are forced low while reset is held.
    always_comb begin
        stall_if  = rst_n & stall_s;
        stall_id  = rst_n & stall_s;
        bubble_ex = rst_n & stall_s;
        flush_id  = rst_n & flush_s;
        flush_ex  = rst_n & flush_s;
        stall_cnt = stall_cnt_r;
        flush_cnt = flush_cnt_r;
    end

    // State, wait counter and statistics registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            wait_cnt_r  <= 3'd0;
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            wait_cnt_r  <= wait_nxt_s;
            stall_cnt_r <= sat_inc(stall_cnt_r, stall_if);
            flush_cnt_r <= sat_inc(flush_cnt_r, flush_ex);
        end
    end

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Bench for forwarding_hazard_unit: three instances (MEM_LAT 0/3/5) share stimulus
// and are compared against a remaining-stall-cycles reference model.
module tb_forwarding_hazard_unit;

    localparam int AW = 5;
    localparam int NS = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n = 1'b1;
    logic [NS*AW-1:0]  ars_id, ars_ex;
    logic [AW-1:0]     ard_id_ex, ard_ex_mem, ard_mem_wb;
    logic              regwrite_id_ex, memread_id_ex, regwrite_ex_mem, regwrite_mem_wb, branch_taken;

    logic [2*NS-1:0]   fwd  [3];
    logic [4:0]        ctl  [3];
    logic [15:0]       scnt [3];
    logic [15:0]       fcnt [3];

    for (genvar k = 0; k < 3; k++) begin : g_dut
        localparam int LT = (k == 0) ? 0 : ((k == 1) ? 3 : 5);
        localparam int CW = (k == 1) ? 4 : 16;
        logic [2*NS-1:0] f;
        logic            si, sd, bx, fi, fe;
        logic [CW-1:0]   sc, fc;
        forwarding_hazard_unit #(.ADDR_W(AW), .NUM_SRC(NS), .MEM_LAT(LT), .CNT_W(CW)) u_dut (
            .clk(clk), .rst_n(rst_n), .ars_id(ars_id), .ars_ex(ars_ex),
            .ard_id_ex(ard_id_ex), .regwrite_id_ex(regwrite_id_ex), .memread_id_ex(memread_id_ex),
            .ard_ex_mem(ard_ex_mem), .ard_mem_wb(ard_mem_wb),
            .regwrite_ex_mem(regwrite_ex_mem), .regwrite_mem_wb(regwrite_mem_wb),
            .branch_taken(branch_taken), .forward(f),
            .stall_if(si), .stall_id(sd), .bubble_ex(bx), .flush_id(fi), .flush_ex(fe),
            .stall_cnt(sc), .flush_cnt(fc));
        assign fwd[k]  = f;
        assign ctl[k]  = {si, sd, bx, fi, fe};
        assign scnt[k] = 16'(sc);
        assign fcnt[k] = 16'(fc);
    end

    int checks = 0;
    int errors = 0;

    int unsigned lat_k [3] = '{0, 3, 5};
    int unsigned cmax  [3] = '{65535, 15, 15 * 0 + 65535};
    int unsigned m_rem [3];
    int unsigned m_scnt[3];
    int unsigned m_fcnt[3];

    typedef struct {
        logic [NS*AW-1:0] ars_id, ars_ex;
        logic [AW-1:0]    ard_id, ard_em, ard_mw;
        logic             rw_id, mr_id, rw_em, rw_mw, br;
        logic [3:0]       exp_fwd;
        logic [4:0]       exp_ctl;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [3:0] ref_fwd();
        logic [3:0] r = 4'b0000;
        for (int i = 0; i < NS; i++) begin
            logic [AW-1:0] s = ars_ex[i*AW +: AW];
            if (regwrite_ex_mem && ard_ex_mem != 5'd0 && ard_ex_mem == s)      r[2*i +: 2] = 2'b10;
            else if (regwrite_mem_wb && ard_mem_wb != 5'd0 && ard_mem_wb == s) r[2*i +: 2] = 2'b01;
        end
        return r;
    endfunction

    function automatic bit ref_lu();
        bit hit = 1'b0;
        for (int i = 0; i < NS; i++)
            if (ars_id[i*AW +: AW] == ard_id_ex) hit = 1'b1;
        return hit && memread_id_ex && regwrite_id_ex && (ard_id_ex != 5'd0);
    endfunction

    task automatic assert_reset();
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            m_rem[k] = 0; m_scnt[k] = 0; m_fcnt[k] = 0;
        end
    endtask

    // Called just after a negedge with inputs applied: compare, then advance the model.
    task automatic eval_cycle();
        logic [3:0] f;
        bit lu, st, fl;
        #2;
        f  = ref_fwd();
        lu = ref_lu();
        for (int k = 0; k < 3; k++) begin
            st = 1'b0; fl = 1'b0;
            if (rst_n) begin
                if (branch_taken)    fl = 1'b1;
                else if (m_rem[k] > 0) st = 1'b1;
                else if (lu)         st = 1'b1;
            end
            chk($sformatf("fwd%0d", k), 32'(fwd[k]), 32'(f));
            chk($sformatf("ctl%0d", k), 32'(ctl[k]), 32'({st, st, st, fl, fl}));
            chk($sformatf("stall_cnt%0d", k), 32'(scnt[k]), m_scnt[k]);
            chk($sformatf("flush_cnt%0d", k), 32'(fcnt[k]), m_fcnt[k]);
            if (!rst_n) begin
                m_rem[k] = 0; m_scnt[k] = 0; m_fcnt[k] = 0;
            end else begin
                if (branch_taken)      m_rem[k] = 0;
                else if (m_rem[k] > 0) m_rem[k] = m_rem[k] - 1;
                else if (lu)           m_rem[k] = lat_k[k];
                if (st && m_scnt[k] < cmax[k]) m_scnt[k]++;
                if (fl && m_fcnt[k] < cmax[k]) m_fcnt[k]++;
            end
        end
    endtask

    task automatic idle_in();
        ars_id = '0; ars_ex = '0; ard_id_ex = 5'd0; ard_ex_mem = 5'd0; ard_mem_wb = 5'd0;
        regwrite_id_ex = 1'b0; memread_id_ex = 1'b0; regwrite_ex_mem = 1'b0;
        regwrite_mem_wb = 1'b0; branch_taken = 1'b0;
    endtask

    task automatic set_lu();
        ard_id_ex = 5'd7; memread_id_ex = 1'b1; regwrite_id_ex = 1'b1;
        ars_id = {5'd7, 5'd3};
    endtask

    task automatic do_reset();
        assert_reset();
        idle_in();
        eval_cycle();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic add(input logic [9:0] aid, input logic [9:0] aex, input logic [4:0] rid,
                       input logic [4:0] rem_, input logic [4:0] rmw, input logic rwi, input logic mri,
                       input logic rwe, input logic rwm, input logic br, input logic [3:0] ef, input logic [4:0] ec);
        vec_t v;
        v.ars_id = aid; v.ars_ex = aex; v.ard_id = rid; v.ard_em = rem_; v.ard_mw = rmw;
        v.rw_id = rwi; v.mr_id = mri; v.rw_em = rwe; v.rw_mw = rwm; v.br = br;
        v.exp_fwd = ef; v.exp_ctl = ec;
        vecs.push_back(v);
    endtask

    initial begin
        int n0, n3, first3, last3;
        // Expected values for the MEM_LAT=0 instance, derived by hand.
        add({5'd0, 5'd5},  {5'd0, 5'd5},   5'd0, 5'd5,  5'd5,  0, 0, 1, 1, 0, 4'b0010, 5'b00000);
        add({5'd0, 5'd5},  {5'd0, 5'd5},   5'd0, 5'd5,  5'd5,  0, 0, 0, 1, 0, 4'b0001, 5'b00000);
        add({5'd0, 5'd0},  {5'd0, 5'd0},   5'd0, 5'd0,  5'd0,  0, 0, 1, 1, 0, 4'b0000, 5'b00000);
        add({5'd0, 5'd0},  {5'd5, 5'd9},   5'd0, 5'd9,  5'd5,  0, 0, 1, 1, 0, 4'b0110, 5'b00000);
        add({5'd0, 5'd0},  {5'd12, 5'd12}, 5'd0, 5'd12, 5'd12, 0, 0, 1, 1, 0, 4'b1010, 5'b00000);
        add({5'd0, 5'd0},  {5'd12, 5'd12}, 5'd0, 5'd12, 5'd12, 0, 0, 0, 1, 0, 4'b0101, 5'b00000);
        add({5'd7, 5'd3},  {5'd0, 5'd0},   5'd7, 5'd0,  5'd0,  1, 1, 0, 0, 0, 4'b0000, 5'b11100);
        add({5'd2, 5'd4},  {5'd0, 5'd0},   5'd4, 5'd0,  5'd0,  1, 1, 0, 0, 0, 4'b0000, 5'b11100);
        add({5'd2, 5'd4},  {5'd0, 5'd0},   5'd4, 5'd0,  5'd0,  1, 0, 0, 0, 0, 4'b0000, 5'b00000);
        add({5'd0, 5'd0},  {5'd0, 5'd0},   5'd0, 5'd0,  5'd0,  1, 1, 0, 0, 0, 4'b0000, 5'b00000);
        add({5'd7, 5'd3},  {5'd0, 5'd0},   5'd7, 5'd0,  5'd0,  1, 1, 0, 0, 1, 4'b0000, 5'b00011);
        add({5'd0, 5'd0},  {5'd0, 5'd0},   5'd0, 5'd0,  5'd0,  0, 0, 0, 0, 1, 4'b0000, 5'b00011);
        add({5'd7, 5'd3},  {5'd0, 5'd0},   5'd7, 5'd0,  5'd0,  0, 1, 0, 0, 0, 4'b0000, 5'b00000);

        for (int k = 0; k < 3; k++) begin
            m_rem[k] = 0; m_scnt[k] = 0; m_fcnt[k] = 0;
        end
        idle_in();
        #1 assert_reset();
        @(negedge clk);

        // Under reset: control outputs low even with a load-use present, forwarding still live.
        set_lu(); ard_ex_mem = 5'd5; regwrite_ex_mem = 1'b1; ars_ex = {5'd0, 5'd5};
        eval_cycle();
        chk("rst_ctl_lat3", 32'(ctl[1]), 32'd0);
        chk("rst_fwd", 32'(fwd[0]), 32'h2);
        @(negedge clk);
        idle_in();
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            ars_id = vecs[i].ars_id; ars_ex = vecs[i].ars_ex; ard_id_ex = vecs[i].ard_id;
            ard_ex_mem = vecs[i].ard_em; ard_mem_wb = vecs[i].ard_mw;
            regwrite_id_ex = vecs[i].rw_id; memread_id_ex = vecs[i].mr_id;
            regwrite_ex_mem = vecs[i].rw_em; regwrite_mem_wb = vecs[i].rw_mw;
            branch_taken = vecs[i].br;
            eval_cycle();
            chk($sformatf("vec%0d_fwd", i), 32'(fwd[0]), 32'(vecs[i].exp_fwd));
            chk($sformatf("vec%0d_ctl", i), 32'(ctl[0]), 32'(vecs[i].exp_ctl));
            @(negedge clk);
        end

        // Single load-use: 1 stall cycle at MEM_LAT=0, 4 consecutive at MEM_LAT=3.
        do_reset();
        n0 = 0; n3 = 0; first3 = -1; last3 = -1;
        for (int c = 0; c < 10; c++) begin
            idle_in();
            if (c == 0) set_lu();
            eval_cycle();
            n0 += int'(ctl[0][4]);
            if (ctl[1][4]) begin
                n3++;
                if (first3 < 0) first3 = c;
                last3 = c;
            end
            @(negedge clk);
        end
        chk("lu_len_lat0", n0, 1);
        chk("lu_len_lat3", n3, 4);
        chk("lu_run_lat3", last3 - first3 + 1, 4);
        chk("stall_cnt_lat0", 32'(scnt[0]), 32'd1);
        chk("stall_cnt_lat3", 32'(scnt[1]), 32'd4);
        chk("stall_cnt_lat5", 32'(scnt[2]), 32'd6);

        // Taken branch in the second stall cycle wins over the stall.
        do_reset();
        idle_in(); set_lu();
        eval_cycle();
        @(negedge clk);
        idle_in(); branch_taken = 1'b1;
        eval_cycle();
        chk("br_in_stall_ctl", 32'(ctl[1]), 32'h03);
        @(negedge clk);
        idle_in();
        eval_cycle();
        chk("br_after_idle", 32'(ctl[1]), 32'h00);
        @(negedge clk);
        chk("br_flush_cnt", 32'(fcnt[1]), 32'd1);
        chk("br_stall_cnt", 32'(scnt[1]), 32'd1);

        // Twenty stall cycles saturate the 4-bit counter.
        do_reset();
        for (int c = 0; c < 20; c++) begin
            idle_in(); set_lu();
            eval_cycle();
            @(negedge clk);
        end
        idle_in();
        chk("sat_cnt4", 32'(scnt[1]), 32'd15);
        chk("nosat_cnt16", 32'(scnt[0]), 32'd20);

        // Asynchronous reset in the middle of a MEM_LAT=5 stall.
        do_reset();
        for (int c = 0; c < 4; c++) begin
            idle_in();
            if (c == 0) set_lu();
            eval_cycle();
            if (c < 3) @(negedge clk);
        end
        chk("pre_rst_stall5", 32'(ctl[2]), 32'h1c);
        #1 assert_reset();
        #1;
        chk("async_rst_ctl5", 32'(ctl[2]), 32'd0);
        chk("async_rst_cnt5", 32'(scnt[2]), 32'd0);
        @(negedge clk);
        eval_cycle();
        @(negedge clk);
        rst_n = 1'b1;
        eval_cycle();
        chk("post_rst_idle5", 32'(ctl[2]), 32'd0);
        @(negedge clk);

        // Randomized traffic with small address range to provoke matches.
        for (int c = 0; c < 400; c++) begin
            ars_id = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
            ars_ex = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
            ard_id_ex = 5'($urandom_range(0, 3));
            ard_ex_mem = 5'($urandom_range(0, 3));
            ard_mem_wb = 5'($urandom_range(0, 3));
            regwrite_id_ex = 1'($urandom_range(0, 1));
            memread_id_ex = 1'($urandom_range(0, 1));
            regwrite_ex_mem = 1'($urandom_range(0, 1));
            regwrite_mem_wb = 1'($urandom_range(0, 1));
            branch_taken = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 99) == 0) assert_reset();
            else rst_n = 1'b1;
            eval_cycle();
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
